// File: rtl/i2c_sim_pkg.sv
// ----------------------------------------------------------------------------
// | Module  : i2c_sim_pkg                                                    |
// | Desc    : Shared types and constants for the simulated I2C target.        |
// | Rev     : 1.0  initial release                                            |
// ----------------------------------------------------------------------------
`default_nettype none

package i2c_sim_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  localparam logic [6:0] C_DEFAULT_TARGET_ADDR = 7'h50;

endpackage

`default_nettype wire

// File: rtl/i2c_sim_sync.sv
// ----------------------------------------------------------------------------
// | Module  : i2c_sim_sync                                                   |
// | Desc    : SCL/SDA synchroniser with START/STOP and SCL edge pulses.       |
// | Rev     : 1.0  initial release                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module i2c_sim_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_sync,
  output logic start_pulse,
  output logic stop_pulse,
  output logic scl_rise,
  output logic scl_fall
);

  logic [SyncStages-1:0] r_scl_pipe;
  logic [SyncStages-1:0] r_sda_pipe;
  logic                  r_scl_prev;
  logic                  r_sda_prev;
  logic                  w_scl;
  logic                  w_sda;

  // Flops reset to 1 so an idle bus after reset produces no spurious edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_scl_pipe <= '1;
      r_sda_pipe <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_pipe <= {r_scl_pipe[SyncStages-2:0], scl_i};
      r_sda_pipe <= {r_sda_pipe[SyncStages-2:0], sda_i};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl       = r_scl_pipe[SyncStages-1];
  assign w_sda       = r_sda_pipe[SyncStages-1];
  assign sda_sync    = w_sda;
  assign start_pulse = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
  assign stop_pulse  = r_scl_prev & w_scl & ~r_sda_prev & w_sda;
  assign scl_rise    = ~r_scl_prev & w_scl;
  assign scl_fall    = r_scl_prev & ~w_scl;

endmodule

`default_nettype wire

// File: rtl/i2c_sim_target.sv
// ----------------------------------------------------------------------------
// | Module  : i2c_sim_target                                                 |
// | Desc    : Simulated I2C target with pointer-addressed flop memory.        |
// | Rev     : 1.0  initial release                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module i2c_sim_target
  import i2c_sim_pkg::*;
#(
  parameter logic [6:0] TargetAddr = C_DEFAULT_TARGET_ADDR,
  parameter int         MemDepth   = 16,
  parameter int         SyncStages = 2,
  parameter logic [7:0] MemInit    = 8'h00
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_en_o,
  output logic                        busy_o,
  output logic                        wr_strobe_o,
  output logic [$clog2(MemDepth)-1:0] wr_addr_o,
  output logic [7:0]                  wr_data_o
);

  localparam int c_ADDR_W = $clog2(MemDepth);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic [7:0]          r_tx;
  logic                r_rw;
  logic                r_nine;
  logic                r_ack_rise;
  logic                r_sda_en;
  logic                r_busy;
  logic                r_wr_strobe;
  logic [c_ADDR_W-1:0] r_wr_addr;
  logic [7:0]          r_wr_data;
  logic [c_ADDR_W-1:0] r_ptr;
  logic [7:0]          r_mem [MemDepth];

  logic       w_sda;
  logic       w_start;
  logic       w_stop;
  logic       w_rise;
  logic       w_fall;
  logic [7:0] w_byte;
  logic       w_sda_nxt;
  logic       w_mem_we;
  logic       w_ptr_ld;
  logic       w_ptr_inc;
  logic       w_tx_ld;
  logic       w_rx_state;
  logic       w_ack_state;

  i2c_sim_sync #(.SyncStages(SyncStages)) u_sync (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .sda_sync    (w_sda),
    .start_pulse (w_start),
    .stop_pulse  (w_stop),
    .scl_rise    (w_rise),
    .scl_fall    (w_fall)
  );

  assign w_byte      = {r_shift[6:0], w_sda};
  assign w_rx_state  = (r_state == ST_ADDR) || (r_state == ST_PTR) ||
                       (r_state == ST_WDATA) || (r_state == ST_RDATA);
  assign w_ack_state = (r_state == ST_ADDR_ACK) || (r_state == ST_PTR_ACK) ||
                       (r_state == ST_WDATA_ACK) || (r_state == ST_RDATA_ACK);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_rise && r_bit_cnt == 3'd7) begin
      case (r_state)
        ST_ADDR:  w_state_nxt = (w_byte[7:1] == TargetAddr) ? ST_ADDR_ACK : ST_IGNORE;
        ST_PTR:   w_state_nxt = ST_PTR_ACK;
        ST_WDATA: w_state_nxt = ST_WDATA_ACK;
        ST_RDATA: w_state_nxt = ST_RDATA_ACK;
        default:  w_state_nxt = r_state;
      endcase
    end else if (w_fall && r_ack_rise) begin
      // Leave an acknowledge slot on the SCL fall that ends its 9th clock.
      case (r_state)
        ST_ADDR_ACK:  w_state_nxt = r_rw ? ST_RDATA : ST_PTR;
        ST_PTR_ACK:   w_state_nxt = ST_WDATA;
        ST_WDATA_ACK: w_state_nxt = ST_WDATA;
        ST_RDATA_ACK: w_state_nxt = r_nine ? ST_IGNORE : ST_RDATA;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_sda_nxt = r_sda_en;
    w_mem_we  = 1'b0;
    w_ptr_ld  = 1'b0;
    w_ptr_inc = 1'b0;
    w_tx_ld   = 1'b0;
    if (w_start || w_stop) begin
      w_sda_nxt = 1'b0;
    end else if (w_rise) begin
      if (r_bit_cnt == 3'd7) begin
        case (r_state)
          ST_PTR:   w_ptr_ld = 1'b1;
          ST_WDATA: begin
            w_mem_we  = 1'b1;
            w_ptr_inc = 1'b1;
          end
          ST_RDATA: w_ptr_inc = 1'b1;
          default:  w_ptr_inc = 1'b0;
        endcase
      end
    end else if (w_fall) begin
      case (r_state)
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (!r_ack_rise) begin
            w_sda_nxt = 1'b1;
          end else if (r_state == ST_ADDR_ACK && r_rw) begin
            w_sda_nxt = ~r_mem[r_ptr][7];
            w_tx_ld   = 1'b1;
          end else begin
            w_sda_nxt = 1'b0;
          end
        end
        ST_RDATA: w_sda_nxt = ~r_tx[3'd7 - r_bit_cnt];
        ST_RDATA_ACK: begin
          if (r_ack_rise && !r_nine) begin
            w_sda_nxt = ~r_mem[r_ptr][7];
            w_tx_ld   = 1'b1;
          end else begin
            w_sda_nxt = 1'b0;
          end
        end
        default: w_sda_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_tx        <= 8'h00;
      r_rw        <= 1'b0;
      r_nine      <= 1'b1;
      r_ack_rise  <= 1'b0;
      r_sda_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
      r_ptr       <= '0;
    end else begin
      r_sda_en    <= w_sda_nxt;
      r_wr_strobe <= w_mem_we;
      if (w_start) begin
        r_bit_cnt  <= 3'd0;
        r_ack_rise <= 1'b0;
        r_busy     <= 1'b1;
      end else if (w_stop) begin
        r_bit_cnt  <= 3'd0;
        r_ack_rise <= 1'b0;
        r_busy     <= 1'b0;
      end else if (w_rise) begin
        if (w_rx_state) begin
          r_shift   <= w_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_state == ST_ADDR && r_bit_cnt == 3'd7) r_rw <= w_sda;
        end else if (w_ack_state) begin
          r_ack_rise <= 1'b1;
          r_nine     <= w_sda;
        end
      end else if (w_fall && w_ack_state) begin
        r_ack_rise <= 1'b0;
      end
      if (w_mem_we) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_byte;
      end
      if (w_ptr_ld)       r_ptr <= w_byte[c_ADDR_W-1:0];
      else if (w_ptr_inc) r_ptr <= r_ptr + 1'b1;
      if (w_tx_ld)        r_tx  <= r_mem[r_ptr];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MemDepth; i++) r_mem[i] <= MemInit;
    end else if (w_mem_we) begin
      r_mem[r_ptr] <= w_byte;
    end
  end

  assign sda_en_o    = r_sda_en;
  assign busy_o      = r_busy;
  assign wr_strobe_o = r_wr_strobe;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_i2c_sim_target.sv
// ----------------------------------------------------------------------------
// | Module  : tb_i2c_sim_target                                              |
// | Desc    : Directed vector bench for the simulated I2C target.             |
// | Rev     : 1.0  initial release                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_i2c_sim_target;

  localparam int Q = 6;

  typedef enum logic [2:0] {
    OP_START, OP_RSTART, OP_STOP, OP_WR, OP_RD_ACK, OP_RD_NACK, OP_CHKWR, OP_MON
  } op_t;

  typedef struct {
    op_t        op;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_en;
  logic       busy;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int         n_tests = 0;
  int         n_fail = 0;
  int         vidx = 0;
  logic [15:0] wlog [256];
  int         wcnt = 0;
  int         rd_idx = 0;
  int         en_cyc = 0;
  int         en_mark = 0;
  vec_t       vecs [$];

  assign sda_bus = sda_m & ~sda_en;

  always #5 clk = ~clk;

  i2c_sim_target dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_en_o    (sda_en),
    .busy_o      (busy),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data)
  );

  always @(negedge clk) begin
    if (wr_strobe && wcnt < 256) begin
      wlog[wcnt] <= {8'(wr_addr), wr_data};
      wcnt <= wcnt + 1;
    end
    if (sda_en) en_cyc <= en_cyc + 1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wt();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wt();
    sda_m = 1'b0; wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wt();
    scl_m = 1'b1; wt();
    sda_m = 1'b0; wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wt();
    scl_m = 1'b1; wt();
    sda_m = 1'b1; wt();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wt();
      scl_m = 1'b1; wt();
      scl_m = 1'b0; wt();
    end
    sda_m = 1'b1; wt();
    scl_m = 1'b1; wt();
    ack = sda_bus;
    scl_m = 1'b0; wt();
  endtask

  task automatic rd_byte(input logic ack_in, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wt();
      scl_m = 1'b1; wt();
      b[i] = sda_bus;
      scl_m = 1'b0; wt();
    end
    sda_m = ack_in; wt();
    scl_m = 1'b1; wt();
    scl_m = 1'b0; wt();
    sda_m = 1'b1;
  endtask

  function automatic void add(input op_t op, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.op   = op;
    v.data = d;
    v.exp  = e;
    vecs.push_back(v);
  endfunction

  task automatic run_vecs();
    logic       ack;
    logic [7:0] b;
    for (int i = 0; i < vecs.size(); i++) begin
      vidx++;
      case (vecs[i].op)
        OP_START: begin
          i2c_start();
          check($sformatf("v%0d_busy_start", vidx), {7'd0, busy}, 8'd1);
        end
        OP_RSTART: i2c_rstart();
        OP_STOP: begin
          i2c_stop();
          check($sformatf("v%0d_busy_stop", vidx), {7'd0, busy}, 8'd0);
        end
        OP_WR: begin
          wr_byte(vecs[i].data, ack);
          check($sformatf("v%0d_ack_%h", vidx, vecs[i].data), {7'd0, ack}, vecs[i].exp);
        end
        OP_RD_ACK, OP_RD_NACK: begin
          rd_byte(vecs[i].op == OP_RD_NACK, b);
          check($sformatf("v%0d_rd", vidx), b, vecs[i].exp);
        end
        OP_CHKWR: begin
          if (rd_idx >= wcnt) begin
            n_tests++;
            n_fail++;
            $display("FAIL v%0d_wr: no strobe seen, expected addr %h data %h",
                     vidx, vecs[i].data, vecs[i].exp);
          end else begin
            check($sformatf("v%0d_wr_addr", vidx), wlog[rd_idx][15:8], vecs[i].data);
            check($sformatf("v%0d_wr_data", vidx), wlog[rd_idx][7:0], vecs[i].exp);
            rd_idx++;
          end
        end
        OP_MON: begin
          if (vecs[i].data[0])
            check($sformatf("v%0d_sda_en_cycles", vidx), 8'(en_cyc - en_mark), vecs[i].exp);
          else
            en_mark = en_cyc;
        end
        default: ;
      endcase
    end
    vecs.delete();
  endtask

  initial begin
    logic ack;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_en", {7'd0, sda_en}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_strobe", {7'd0, wr_strobe}, 8'd0);
    check("rst_wr_addr", {4'd0, wr_addr}, 8'd0);
    check("rst_wr_data", wr_data, 8'd0);
    rst = 1'b0;
    wt();

    // Single write to location 3.
    add(OP_START, 0, 0); add(OP_WR, 8'hA0, 0); add(OP_WR, 8'h03, 0);
    add(OP_WR, 8'hA5, 0); add(OP_STOP, 0, 0); add(OP_CHKWR, 8'h03, 8'hA5);
    // Pointer write, repeated START, one-byte read.
    add(OP_START, 0, 0); add(OP_WR, 8'hA0, 0); add(OP_WR, 8'h03, 0);
    add(OP_RSTART, 0, 0); add(OP_WR, 8'hA1, 0); add(OP_RD_NACK, 0, 8'hA5);
    add(OP_STOP, 0, 0);
    // Address mismatch: no ACK and SDA never driven.
    add(OP_MON, 0, 0); add(OP_START, 0, 0); add(OP_WR, 8'hA2, 1);
    add(OP_WR, 8'h55, 1); add(OP_MON, 1, 0); add(OP_STOP, 0, 0);
    // Write wrap at the top of memory.
    add(OP_START, 0, 0); add(OP_WR, 8'hA0, 0); add(OP_WR, 8'h0F, 0);
    add(OP_WR, 8'h11, 0); add(OP_WR, 8'h22, 0); add(OP_STOP, 0, 0);
    add(OP_CHKWR, 8'h0F, 8'h11); add(OP_CHKWR, 8'h00, 8'h22);
    // Burst read 14, 15, 0.
    add(OP_START, 0, 0); add(OP_WR, 8'hA0, 0); add(OP_WR, 8'h0E, 0);
    add(OP_WR, 8'h33, 0); add(OP_WR, 8'h44, 0); add(OP_STOP, 0, 0);
    add(OP_CHKWR, 8'h0E, 8'h33); add(OP_CHKWR, 8'h0F, 8'h44);
    add(OP_START, 0, 0); add(OP_WR, 8'hA0, 0); add(OP_WR, 8'h0E, 0);
    add(OP_RSTART, 0, 0); add(OP_WR, 8'hA1, 0); add(OP_RD_ACK, 0, 8'h33);
    add(OP_RD_ACK, 0, 8'h44); add(OP_RD_NACK, 0, 8'h22); add(OP_STOP, 0, 0);
    // Pointer persists (now 1): read of untouched location gives reset value.
    add(OP_START, 0, 0); add(OP_WR, 8'hA1, 0); add(OP_RD_NACK, 0, 8'h00);
    add(OP_STOP, 0, 0);
    run_vecs();

    // Reset while the target drives a 0 data bit (mem[2] = 0x00).
    i2c_start();
    wr_byte(8'hA1, ack);
    check("rstmid_ack", {7'd0, ack}, 8'd0);
    check("rstmid_driving", {7'd0, sda_en}, 8'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_sda_async", {7'd0, sda_en}, 8'd0);
    check("rstmid_busy", {7'd0, busy}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wt();
    scl_m = 1'b1;
    wt();

    add(OP_START, 0, 0); add(OP_WR, 8'hA0, 0); add(OP_WR, 8'h05, 0);
    add(OP_WR, 8'h77, 0); add(OP_STOP, 0, 0); add(OP_CHKWR, 8'h05, 8'h77);
    add(OP_START, 0, 0); add(OP_WR, 8'hA0, 0); add(OP_WR, 8'h03, 0);
    add(OP_RSTART, 0, 0); add(OP_WR, 8'hA1, 0); add(OP_RD_NACK, 0, 8'h00);
    add(OP_STOP, 0, 0);
    add(OP_START, 0, 0); add(OP_WR, 8'hA0, 0); add(OP_WR, 8'h05, 0);
    add(OP_RSTART, 0, 0); add(OP_WR, 8'hA1, 0); add(OP_RD_ACK, 0, 8'h77);
    add(OP_RD_NACK, 0, 8'h00); add(OP_STOP, 0, 0);
    run_vecs();

    check("no_extra_strobes", 8'(wcnt - rd_idx), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
